draw_ball: RTL and testbench

- Pixel-pipeline stage directly downstream of the racket-drawing stage; consumes its timing signals and RGB stream.
- Overlays a square ball onto the RGB stream and owns the ball motion FSM: serve, move, bounce off walls and rackets, score.
- Ball position updates once per frame, on the rising edge of vblnk_in, so the visible frame never tears.

---
 rtl/draw_ball.sv | 214 +++++++++++++++++++++
 tb/tb_draw_ball.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_ball.sv
// rtl/draw_ball.sv - ball overlay and per-frame ball motion FSM (serve, move, bounce, score)
// Optional DRAW_BALL_SPEEDUP_EN: each racket bounce raises speed up to MAX_SPEED.
module draw_ball #(
   parameter int H_RES        = 1024,
   parameter int V_RES        = 768,
   parameter int SIZE         = 10,
   parameter int SPEED        = 4,
   parameter int MAX_SPEED    = 12,
   parameter int RACKET_LEN   = 80,
   parameter int L_FACE       = 60,
   parameter int R_FACE       = 963,
   parameter int SERVE_FRAMES = 60
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] vcount_in,
   input  logic [10:0] hcount_in,
   input  logic        vsync_in,
   input  logic        hsync_in,
   input  logic        vblnk_in,
   input  logic        hblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [11:0] y_pos,
   input  logic [9:0]  y_pos_sec,
   input  logic [11:0] ball_color,
   input  logic        start,
   output logic [10:0] vcount_out,
   output logic [10:0] hcount_out,
   output logic        vsync_out,
   output logic        hsync_out,
   output logic        vblnk_out,
   output logic        hblnk_out,
   output logic [11:0] rgb_out,
   output logic [10:0] ball_x,
   output logic [10:0] ball_y,
   output logic        point_left,
   output logic        point_right
);

   typedef enum logic [1:0] {IDLE, SERVE, MOVE, SCORED} state_t;

   localparam int          CW      = $clog2(SERVE_FRAMES + 1);
   localparam logic [10:0] X_C     = 11'((H_RES - SIZE) / 2);
   localparam logic [10:0] Y_C     = 11'((V_RES - SIZE) / 2);
   localparam logic [12:0] S13     = 13'(SIZE);
   localparam logic [12:0] H13     = 13'(H_RES);
   localparam logic [12:0] V13     = 13'(V_RES);
   localparam logic [12:0] L13     = 13'(L_FACE);
   localparam logic [12:0] R13     = 13'(R_FACE);
   localparam logic [12:0] RL13    = 13'(RACKET_LEN);
   localparam logic [3:0]  SPD_RST = 4'(SPEED);

   state_t          state, state_nxt;
   logic [10:0]     x_nxt, y_nxt;
   logic            dx, dx_nxt, dy, dy_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            pl_nxt, pr_nxt;
   logic [3:0]      speed;
`ifdef DRAW_BALL_SPEEDUP_EN
   logic [3:0]      speed_nxt;
   logic [3:0]      speed_up;
   assign speed_up = (speed >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : speed + 4'd1;
`else
   assign speed = (SPEED > MAX_SPEED) ? 4'(MAX_SPEED) : SPD_RST;
`endif

   logic        tick;
   logic [12:0] x13, y13, sp13, top_l, top_r, h13, v13;
   logic        ov_l, ov_r, in_ball;

   // vblnk_out is already the registered copy of vblnk_in
   assign tick  = vblnk_in & ~vblnk_out;
   assign x13   = {2'b00, ball_x};
   assign y13   = {2'b00, ball_y};
   assign sp13  = {9'd0, speed};
   assign top_l = {1'b0, y_pos};
   assign top_r = {3'b000, y_pos_sec};
   assign ov_l  = (y13 + S13 > top_l) && (y13 < top_l + RL13);
   assign ov_r  = (y13 + S13 > top_r) && (y13 < top_r + RL13);
   assign h13   = {2'b00, hcount_in};
   assign v13   = {2'b00, vcount_in};
   assign in_ball = (h13 >= x13) && (h13 < x13 + S13) && (v13 >= y13) && (v13 < y13 + S13);

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      x_nxt     = ball_x;
      y_nxt     = ball_y;
      dx_nxt    = dx;
      dy_nxt    = dy;
      cnt_nxt   = cnt;
      pl_nxt    = 1'b0;
      pr_nxt    = 1'b0;
`ifdef DRAW_BALL_SPEEDUP_EN
      speed_nxt = speed;
`endif
      case (state)
         IDLE: begin
            if (tick && start) begin
               state_nxt = SERVE;
               cnt_nxt   = '0;
            end
         end
         SERVE: begin
            if (tick) begin
               cnt_nxt = cnt + 1'b1;
               if (cnt_nxt == CW'(SERVE_FRAMES)) state_nxt = MOVE;
            end
         end
         MOVE: begin
            if (tick) begin
               if (!dy) begin
                  if (y13 < sp13) begin
                     y_nxt  = '0;
                     dy_nxt = 1'b1;
                  end else begin
                     y_nxt = ball_y - 11'(speed);
                  end
               end else if (y13 + S13 + sp13 > V13) begin
                  y_nxt  = 11'(V_RES - SIZE);
                  dy_nxt = 1'b0;
               end else begin
                  y_nxt = ball_y + 11'(speed);
               end

               if (!dx) begin
                  if (x13 >= L13 && x13 - sp13 < L13 && ov_l) begin
                     x_nxt  = 11'(L_FACE);
                     dx_nxt = 1'b1;
`ifdef DRAW_BALL_SPEEDUP_EN
                     speed_nxt = speed_up;
`endif
                  end else if (x13 < sp13) begin
                     state_nxt = SCORED;
                     pr_nxt    = 1'b1;
                  end else begin
                     x_nxt = ball_x - 11'(speed);
                  end
               end else begin
                  if (x13 + S13 <= R13 && x13 + S13 + sp13 > R13 && ov_r) begin
                     x_nxt  = 11'(R_FACE - SIZE);
                     dx_nxt = 1'b0;
`ifdef DRAW_BALL_SPEEDUP_EN
                     speed_nxt = speed_up;
`endif
                  end else if (x13 + S13 + sp13 > H13) begin
                     state_nxt = SCORED;
                     pl_nxt    = 1'b1;
                  end else begin
                     x_nxt = ball_x + 11'(speed);
                  end
               end
            end
         end
         SCORED: begin
            // serve toward the player who just lost the point
            x_nxt     = X_C;
            y_nxt     = Y_C;
            dx_nxt    = ~point_right;
            cnt_nxt   = '0;
            state_nxt = SERVE;
`ifdef DRAW_BALL_SPEEDUP_EN
            speed_nxt = SPD_RST;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         vcount_out  <= '0;
         hcount_out  <= '0;
         vsync_out   <= 1'b0;
         hsync_out   <= 1'b0;
         vblnk_out   <= 1'b0;
         hblnk_out   <= 1'b0;
         rgb_out     <= '0;
         ball_x      <= X_C;
         ball_y      <= Y_C;
         dx          <= 1'b1;
         dy          <= 1'b1;
         cnt         <= '0;
         point_left  <= 1'b0;
         point_right <= 1'b0;
`ifdef DRAW_BALL_SPEEDUP_EN
         speed       <= SPD_RST;
`endif
      end else begin
         vcount_out  <= vcount_in;
         hcount_out  <= hcount_in;
         vsync_out   <= vsync_in;
         hsync_out   <= hsync_in;
         vblnk_out   <= vblnk_in;
         hblnk_out   <= hblnk_in;
         rgb_out     <= in_ball ? ball_color : rgb_in;
         ball_x      <= x_nxt;
         ball_y      <= y_nxt;
         dx          <= dx_nxt;
         dy          <= dy_nxt;
         cnt         <= cnt_nxt;
         point_left  <= pl_nxt;
         point_right <= pr_nxt;
`ifdef DRAW_BALL_SPEEDUP_EN
         speed       <= speed_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_draw_ball.sv
// tb/tb_draw_ball.sv - scoreboard bench for draw_ball against a frame-level reference model
module tb_draw_ball;

   logic        pclk = 1'b0;
   logic        rst;
   logic [10:0] vcount_in, hcount_in;
   logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
   logic [11:0] rgb_in, y_pos, ball_color;
   logic [9:0]  y_pos_sec;
   logic        start;
   logic [10:0] vcount_out, hcount_out, ball_x, ball_y;
   logic        vsync_out, hsync_out, vblnk_out, hblnk_out, point_left, point_right;
   logic [11:0] rgb_out;

   int total = 0;
   int bad   = 0;

   typedef struct {int x; int y; bit pl; bit pr;} exp_t;
   typedef struct {logic [11:0] rgb; logic hs; logic [10:0] h;} px_t;
   exp_t sbq[$];
   px_t  pxq[$];

   int m_x, m_y, m_dx, m_dy, m_sp, m_cnt, m_st;
   bit left_ok;

   always #5 pclk = ~pclk;

   draw_ball dut (
      .pclk(pclk), .rst(rst),
      .vcount_in(vcount_in), .hcount_in(hcount_in),
      .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
      .rgb_in(rgb_in), .y_pos(y_pos), .y_pos_sec(y_pos_sec), .ball_color(ball_color),
      .start(start),
      .vcount_out(vcount_out), .hcount_out(hcount_out),
      .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
      .rgb_out(rgb_out), .ball_x(ball_x), .ball_y(ball_y),
      .point_left(point_left), .point_right(point_right)
   );

   task automatic model_reset();
      m_x = 507; m_y = 379; m_dx = 1; m_dy = 1; m_sp = 4; m_cnt = 0; m_st = 0;
   endtask

   task automatic model_bump();
`ifdef DRAW_BALL_SPEEDUP_EN
      m_sp = (m_sp + 1 > 12) ? 12 : m_sp + 1;
`endif
   endtask

   // states: 0 idle, 1 serve, 2 move
   task automatic model_step(output bit pl, output bit pr);
      int ox, oy, tl, tr;
      bit hit_l, hit_r;
      pl = 0; pr = 0;
      ox = m_x; oy = m_y; tl = int'(y_pos); tr = int'(y_pos_sec);
      hit_l = (oy + 10 > tl) && (oy < tl + 80);
      hit_r = (oy + 10 > tr) && (oy < tr + 80);
      if (m_st == 0) begin
         if (start) begin m_st = 1; m_cnt = 0; end
      end else if (m_st == 1) begin
         m_cnt++;
         if (m_cnt == 60) m_st = 2;
      end else begin
         if (m_dy < 0) begin
            if (oy < m_sp) begin m_y = 0; m_dy = 1; end
            else m_y = oy - m_sp;
         end else if (oy + 10 + m_sp > 768) begin
            m_y = 758; m_dy = -1;
         end else m_y = oy + m_sp;
         if (m_dx < 0) begin
            if (ox >= 60 && ox - m_sp < 60 && hit_l) begin m_x = 60; m_dx = 1; model_bump(); end
            else if (ox < m_sp) pr = 1;
            else m_x = ox - m_sp;
         end else begin
            if (ox + 10 <= 963 && ox + 10 + m_sp > 963 && hit_r) begin m_x = 953; m_dx = -1; model_bump(); end
            else if (ox + 10 + m_sp > 1024) pl = 1;
            else m_x = ox + m_sp;
         end
      end
   endtask

   task automatic do_tick(output bit scored);
      exp_t e;
      bit pl, pr;
      y_pos     = left_ok ? 12'(m_y) : 12'd2000;
      y_pos_sec = 10'(m_y);
      @(negedge pclk) vblnk_in = 1'b0;
      @(negedge pclk) vblnk_in = 1'b1;
      model_step(pl, pr);
      e.x = m_x; e.y = m_y; e.pl = pl; e.pr = pr;
      sbq.push_back(e);
      @(negedge pclk);
      e = sbq.pop_front();
      total++;
      if (ball_x !== 11'(e.x) || ball_y !== 11'(e.y)) begin
         bad++;
         $display("FAIL ball_pos got (%0d,%0d) expected (%0d,%0d)", ball_x, ball_y, e.x, e.y);
      end
      total++;
      if (point_left !== e.pl || point_right !== e.pr) begin
         bad++;
         $display("FAIL points got l=%0b r=%0b expected l=%0b r=%0b", point_left, point_right, e.pl, e.pr);
      end
      scored = pl | pr;
      if (scored) begin
         m_x = 507; m_y = 379; m_dx = pr ? -1 : 1; m_sp = 4; m_cnt = 0; m_st = 1;
         @(negedge pclk);
         total++;
         if (point_left !== 1'b0 || point_right !== 1'b0 || ball_x !== 11'd507 || ball_y !== 11'd379) begin
            bad++;
            $display("FAIL score_recentre got l=%0b r=%0b (%0d,%0d) expected 0 0 (507,379)",
                     point_left, point_right, ball_x, ball_y);
         end
      end
   endtask

   task automatic run_ticks(input int n);
      bit sc;
      for (int i = 0; i < n; i++) do_tick(sc);
   endtask

   task automatic check_cleared(input string name);
      total++;
      if (rgb_out !== 12'h0 || hcount_out !== 11'd0 || vcount_out !== 11'd0 || hsync_out !== 1'b0 ||
          vsync_out !== 1'b0 || hblnk_out !== 1'b0 || vblnk_out !== 1'b0 ||
          point_left !== 1'b0 || point_right !== 1'b0 || ball_x !== 11'd507 || ball_y !== 11'd379) begin
         bad++;
         $display("FAIL %s got rgb=%h h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b ball=(%0d,%0d) expected zeros ball=(507,379)",
                  name, rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, ball_x, ball_y);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; vcount_in = '0; hcount_in = '0;
      vsync_in = 0; hsync_in = 0; vblnk_in = 0; hblnk_in = 0;
      rgb_in = 12'h000; ball_color = 12'hFFF; y_pos = 12'd2000; y_pos_sec = '0;
      left_ok = 1;
      model_reset();
      repeat (3) @(negedge pclk);
      check_cleared("reset_state");
      rst = 1'b1;
   endtask

   task automatic test_overlay();
      int hs[8] = '{507, 517, 516, 506, 507, 512, 0, 510};
      int vs[8] = '{379, 379, 388, 379, 389, 384, 0, 380};
      logic [11:0] bg[8] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h5A5, 12'h5A5, 12'h123, 12'h000};
      px_t p, q;
      for (int i = 0; i <= 8; i++) begin
         @(negedge pclk);
         if (i > 0) begin
            q = pxq.pop_front();
            total++;
            if (rgb_out !== q.rgb || hsync_out !== q.hs || hcount_out !== q.h) begin
               bad++;
               $display("FAIL overlay_px%0d got rgb=%h hs=%0b h=%0d expected rgb=%h hs=%0b h=%0d",
                        i - 1, rgb_out, hsync_out, hcount_out, q.rgb, q.hs, q.h);
            end
         end
         if (i < 8) begin
            hcount_in = 11'(hs[i]); vcount_in = 11'(vs[i]); rgb_in = bg[i]; hsync_in = i[0];
            p.rgb = (hs[i] >= m_x && hs[i] < m_x + 10 && vs[i] >= m_y && vs[i] < m_y + 10) ? ball_color : bg[i];
            p.hs  = hsync_in;
            p.h   = hcount_in;
            pxq.push_back(p);
         end
      end
      hcount_in = '0; vcount_in = '0; rgb_in = 12'h000; hsync_in = 0;
   endtask

   task automatic test_idle(input int n);
      start = 1'b0;
      run_ticks(n);
   endtask

   task automatic test_serve();
      bit sc;
      start = 1'b1;
      do_tick(sc);
      start = 1'b0;
      run_ticks(61);
      total++;
      if (ball_x !== 11'd511) begin
         bad++;
         $display("FAIL serve_first_move got %0d expected 511", ball_x);
      end
   endtask

   task automatic test_rally();
      left_ok = 1;
      run_ticks(560);
   endtask

   task automatic test_miss();
      bit sc;
      int n;
      left_ok = 0;
      sc = 0; n = 0;
      while (!sc && n < 600) begin
         do_tick(sc);
         n++;
      end
      total++;
      if (!sc) begin
         bad++;
         $display("FAIL miss_score_timeout got no score after %0d ticks expected a score", n);
      end
   endtask

   task automatic test_back_to_back();
      left_ok = 1;
      run_ticks(75);
   endtask

   task automatic test_reset_mid();
      @(negedge pclk);
      hsync_in = 1; vsync_in = 1; hblnk_in = 1; rgb_in = 12'hABC;
      hcount_in = 11'd100; vcount_in = 11'd200;
      @(posedge pclk);
      #2 rst = 1'b0;
      #1 check_cleared("reset_mid_line");
      @(negedge pclk);
      hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0; rgb_in = 12'h000;
      hcount_in = '0; vcount_in = '0;
      model_reset();
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_overlay();
      test_idle(3);
      test_serve();
      test_rally();
      test_miss();
      test_back_to_back();
      test_reset_mid();
      test_idle(2);
      test_overlay();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
